// File: rtl/mu0_ctrl_pkg.sv
// Shared encodings for the MU0 control sequencer: FSM states, opcodes and ALU function codes.
package mu0_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] PASS_Y = 2'b00;
    localparam logic [1:0] ADD    = 2'b01;
    localparam logic [1:0] SUB    = 2'b10;
    localparam logic [1:0] INC_X  = 2'b11;

endpackage

// File: rtl/mu0_wait_timer.sv
// Saturating wait-state counter for a pending memory access.
// Raises timeout on the MAX_WAIT-th consecutive cycle without an acknowledge.
module mu0_wait_timer
    import mu0_ctrl_pkg::*;
#(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    input  logic clr,
    output logic timeout
);

    localparam logic [WAIT_W:0] LIMIT = (WAIT_W+1)'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W:0]   cnt_inc;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + WAIT_W'(1);
    endfunction

    // cnt_inc counts the current cycle too, so an ack-less cycle that brings it
    // to the limit is the last one allowed; an ack on that cycle still wins.
    assign cnt_inc = {1'b0, cnt} + (WAIT_W+1)'(1);
    assign timeout = (MAX_WAIT != 0) && req && !ack && (cnt_inc == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clr || ack || !req)
            cnt <= '0;
        else
            cnt <= sat_inc(cnt);
    end

endmodule

// File: rtl/mu0_ctrl_seq.sv
// MU0 fetch/execute control sequencer: decodes the opcode and drives the datapath
// selects, register enables and memory handshake, with a bus-error timeout.
module mu0_ctrl_seq
    import mu0_ctrl_pkg::*;
#(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       Mem_Ack,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic [1:0] ALU_fs,
    output logic       Acc_En,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Rd,
    output logic       Wr,
    output logic       Halted,
    output logic       Bus_Err
);

    state_t state, state_nx;
    logic   acc_c, pc_c, ir_c, rd_c, wr_c;
    logic   timeout;
    logic   bus_err;

    always_comb begin
        state_nx = state;
        X_sel    = 1'b0;
        Y_sel    = 1'b0;
        Addr_sel = 1'b0;
        ALU_fs   = PASS_Y;
        acc_c    = 1'b0;
        pc_c     = 1'b0;
        ir_c     = 1'b0;
        rd_c     = 1'b0;
        wr_c     = 1'b0;
        case (state)
            FETCH: begin
                rd_c   = 1'b1;
                X_sel  = 1'b1;
                ALU_fs = INC_X;
                ir_c   = Mem_Ack;
                pc_c   = Mem_Ack;
                if (Mem_Ack) state_nx = EXEC;
            end
            EXEC: begin
                case (F)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        Addr_sel = 1'b1;
                        rd_c     = 1'b1;
                        acc_c    = Mem_Ack;
                        if (F == OP_ADD) ALU_fs = ADD;
                        else if (F == OP_SUB) ALU_fs = SUB;
                        if (Mem_Ack) state_nx = FETCH;
                    end
                    OP_STA: begin
                        Addr_sel = 1'b1;
                        wr_c     = 1'b1;
                        if (Mem_Ack) state_nx = FETCH;
                    end
                    OP_JMP: begin
                        Y_sel    = 1'b1;
                        pc_c     = 1'b1;
                        state_nx = FETCH;
                    end
                    OP_JGE: begin
                        Y_sel    = !N;
                        pc_c     = !N;
                        state_nx = FETCH;
                    end
                    OP_JNE: begin
                        Y_sel    = !Z;
                        pc_c     = !Z;
                        state_nx = FETCH;
                    end
                    OP_STP:  state_nx = HALT;
                    default: state_nx = FETCH;
                endcase
            end
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
        if (timeout) state_nx = HALT;
    end

    // Reset must kill any in-flight request combinationally, not a cycle later.
    assign Acc_En  = acc_c & ~Reset;
    assign PC_En   = pc_c & ~Reset;
    assign IR_En   = ir_c & ~Reset;
    assign Rd      = rd_c & ~Reset;
    assign Wr      = wr_c & ~Reset;
    assign Halted  = (state == HALT) & ~Reset;
    assign Bus_Err = bus_err & ~Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= FETCH;
            bus_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (timeout) bus_err <= 1'b1;
        end
    end

    mu0_wait_timer #(
        .WAIT_W  (WAIT_W),
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk    (Clk),
        .rst    (Reset),
        .req    (rd_c | wr_c),
        .ack    (Mem_Ack),
        .clr    (state_nx != state),
        .timeout(timeout)
    );

endmodule
